// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the MIPS front end: opcode and ALUOp codes, plus the
// fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC arithmetic: sequential pc+4, or the branch target when the consumed
// instruction redirects. All sums wrap modulo 2^ADDR_W.
module pc_next_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] offset_bytes;

  always_comb begin
    pc_plus4     = pc + ADDR_W'(4);
    offset_bytes = branch_taken ? (branch_offset << 2) : '0;
    pc_next      = pc_plus4 + offset_bytes;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch front end: one outstanding imem request, registered
// instruction handed to decode with a valid/ready handshake.
//
//   state    | meaning
//   ST_RST   | just out of reset, no request yet
//   ST_FETCH | imem_req high at pc, waiting for imem_rvalid
//   ST_HOLD  | instr/pc valid, waiting for decode to consume
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] instr_q;
  logic [31:0]       count_q;
  logic              consume;
  logic              capture;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_plus4      (pc_plus4),
    .pc_next       (pc_next)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    consume = 1'b0;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // rvalid here is stray traffic and deliberately ignored
        if (instr_ready) begin
          consume = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) instr_q <= imem_rdata;
      if (consume) begin
        pc_q    <= pc_next;
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = opcode_of(32'(instr_q));
  assign instr_valid = (state_q == ST_HOLD);
  assign pc          = pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, latency/spurious/reset
// sequences, a wrap instance, and a randomized run against a PC/count model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] fetch_count;

  logic        req_w;
  logic [31:0] addr_w;
  logic        rvalid_w;
  logic [31:0] rdata_w;
  logic [31:0] instr_w;
  logic [5:0]  opcode_w;
  logic        valid_w;
  logic        ready_w;
  logic [31:0] pc_w;
  logic [31:0] pc4_w;
  logic        br_w;
  logic [31:0] off_w;
  logic [31:0] cnt_w;

  int n_checks = 0;
  int n_errors = 0;

  int lat_cfg = 1;
  int wait_cnt;
  logic spur_en = 1'b0;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(req_w), .imem_addr(addr_w),
    .imem_rvalid(rvalid_w), .imem_rdata(rdata_w), .instr(instr_w), .opcode(opcode_w),
    .instr_valid(valid_w), .instr_ready(ready_w), .pc(pc_w), .pc_plus4(pc4_w),
    .branch_taken(br_w), .branch_offset(off_w), .fetch_count(cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C01_0004;
    return (a * 32'h0001_0003) ^ 32'h2B5A_0000;
  endfunction

  // memory: rvalid on the lat_cfg-th cycle of a request; optional stray rvalid when idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (imem_req && !imem_rvalid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign imem_rvalid = (imem_req && (wait_cnt == lat_cfg - 1)) || (spur_en && !imem_req);
  assign imem_rdata  = mem_word(imem_addr);

  assign rvalid_w = req_w;
  assign rdata_w  = mem_word(addr_w);
  assign ready_w  = 1'b1;
  assign br_w     = 1'b0;
  assign off_w    = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        br;
    logic [31:0] off;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic [31:0] o,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] c);
    vec_t t;
    t.ready = r; t.br = b; t.off = o; t.e_req = q; t.e_addr = a;
    t.e_valid = v; t.e_pc = p; t.e_cnt = c;
    return t;
  endfunction

  vec_t tbl[21];

  task automatic do_reset();
    instr_ready = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0; spur_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_cnt"},   fetch_count, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [15:0] imm;

    rst_n = 1'b1;
    tbl[0]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 32'h0,  0, 32'h0,  0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0);
    tbl[6]  = mk(1, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0);
    tbl[7]  = mk(0, 1, 32'hFFFF_FFFF, 1, 32'h4,  0, 32'h4,  1);
    tbl[8]  = mk(0, 1, 32'h7,        0, 32'h0,  1, 32'h4,  1);
    tbl[9]  = mk(1, 0, 32'h0,        0, 32'h0,  1, 32'h4,  1);
    tbl[10] = mk(1, 0, 32'h0,        1, 32'h8,  0, 32'h8,  2);
    tbl[11] = mk(1, 0, 32'h0,        0, 32'h0,  1, 32'h8,  2);
    tbl[12] = mk(1, 0, 32'h0,        1, 32'hC,  0, 32'hC,  3);
    tbl[13] = mk(1, 0, 32'h0,        0, 32'h0,  1, 32'hC,  3);
    tbl[14] = mk(1, 0, 32'h0,        1, 32'h10, 0, 32'h10, 4);
    tbl[15] = mk(1, 1, 32'hFFFF_FFFE, 0, 32'h0,  1, 32'h10, 4);
    tbl[16] = mk(1, 0, 32'h0,        1, 32'hC,  0, 32'hC,  5);
    tbl[17] = mk(1, 0, 32'h0,        0, 32'h0,  1, 32'hC,  5);
    tbl[18] = mk(1, 0, 32'h0,        1, 32'h10, 0, 32'h10, 6);
    tbl[19] = mk(1, 0, 32'hFFFF_FFFE, 0, 32'h0,  1, 32'h10, 6);
    tbl[20] = mk(0, 0, 32'h0,        1, 32'h14, 0, 32'h14, 7);

    // directed table, 1-cycle memory
    lat_cfg = 1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("t%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      chk($sformatf("t%0d_pc", i),    pc, tbl[i].e_pc);
      chk($sformatf("t%0d_pc4", i),   pc_plus4, tbl[i].e_pc + 32'd4);
      chk($sformatf("t%0d_cnt", i),   fetch_count, tbl[i].e_cnt);
      if (tbl[i].e_valid) begin
        w = mem_word(tbl[i].e_pc);
        chk($sformatf("t%0d_instr", i),  instr, w);
        chk($sformatf("t%0d_opcode", i), 32'(opcode), 32'(w[31:26]));
      end
      if (i == 2) begin
        chk("first_instr", instr, 32'h8C01_0004);
        chk("first_opcode", 32'(opcode), 32'h23);
      end
      if (i == 1) chk("wrap_addr0", addr_w, 32'hFFFF_FFFC);
      if (i == 2) chk("wrap_pc4", pc4_w, 32'h0);
      if (i == 3) begin
        chk("wrap_req", 32'(req_w), 32'h1);
        chk("wrap_addr1", addr_w, 32'h0);
      end
      instr_ready   = tbl[i].ready;
      branch_taken  = tbl[i].br;
      branch_offset = tbl[i].off;
    end

    // 4-cycle memory, stray rvalid while holding
    lat_cfg = 4;
    do_reset();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("lat4_req%0d", c),   32'(imem_req), 32'h1);
      chk($sformatf("lat4_addr%0d", c),  imem_addr, 32'h0);
      chk($sformatf("lat4_valid%0d", c), 32'(instr_valid), 32'h0);
      @(negedge clk);
    end
    chk("lat4_valid", 32'(instr_valid), 32'h1);
    chk("lat4_instr", instr, 32'h8C01_0004);
    spur_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("spur_valid%0d", c), 32'(instr_valid), 32'h1);
      chk($sformatf("spur_req%0d", c),   32'(imem_req), 32'h0);
      chk($sformatf("spur_instr%0d", c), instr, 32'h8C01_0004);
      chk($sformatf("spur_pc%0d", c),    pc, 32'h0);
      chk($sformatf("spur_cnt%0d", c),   fetch_count, 32'h0);
    end
    spur_en = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("post_spur_addr", imem_addr, 32'h4);
    chk("post_spur_cnt", fetch_count, 32'h1);

    // reset in the middle of FETCH
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_fetch");
    @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 1;
    @(negedge clk);
    chk("refetch1_req", 32'(imem_req), 32'h1);
    chk("refetch1_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("refetch1_valid", 32'(instr_valid), 32'h1);

    // reset in the middle of HOLD
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("refetch2_req", 32'(imem_req), 32'h1);
    chk("refetch2_addr", imem_addr, 32'h0);

    // randomized run against a pc/count model
    do_reset();
    m_pc = 32'h0;
    m_cnt = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("rnd_pc_align", 32'(pc[1:0]), 32'h0);
      chk("rnd_cnt", fetch_count, m_cnt);
      if (imem_req) begin
        chk("rnd_addr", imem_addr, m_pc);
        chk("rnd_req_valid", 32'(instr_valid), 32'h0);
      end
      if (instr_valid) begin
        w = mem_word(m_pc);
        chk("rnd_pc", pc, m_pc);
        chk("rnd_instr", instr, w);
        chk("rnd_opcode", 32'(opcode), 32'(w[31:26]));
        chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
      end
      instr_ready   = ($urandom_range(0, 2) != 0);
      branch_taken  = $urandom_range(0, 1) == 1;
      imm           = 16'($urandom());
      branch_offset = {{16{imm[15]}}, imm};
      spur_en       = $urandom_range(0, 3) == 0;
      if (!imem_req) lat_cfg = $urandom_range(1, 4);
      if (instr_valid && instr_ready) begin
        m_pc  = m_pc + 32'd4 + (branch_taken ? (branch_offset << 2) : 32'h0);
        m_cnt = m_cnt + 32'd1;
      end
    end
    chk("rnd_progress", 32'(m_cnt > 32'd200), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
